panel_ctrl: RTL and testbench
=============================

Name: panel_ctrl

Overview:
Front-panel run/halt sequencer for the PDP-8 CPU. It synchronises and debounces the raw panel switches CLEAR, RUN, HALT and STEP. It sequences the CPU between cleared, halted, running and single-step operation, and it only stops the CPU on instruction boundaries. It sits between the board pins and the CPU's phase sequencer and drives the CPU run-enable and clear strobe.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive SYSCLK cycles a synchronised switch level must differ from its debounced value before the debounced value flips (>=2)
CLEAR_CYCLES, 4, length in SYSCLK cycles of the cpuClear strobe (>=1)

Ports:
SYSCLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
sw_CLEAR  in  1  raw panel switch, asynchronous, active-high, bouncy
sw_RUN  in  1  raw panel switch, as above
sw_HALT  in  1  raw panel switch, as above
sw_STEP  in  1  raw panel switch, as above
instDone  in  1  one-cycle pulse from CPU on the last phase of every instruction
instHLT  in  1  high with instDone when the completed instruction was an OPR HLT
cpuRun  out  1  enables the CPU phase sequencer
cpuClear  out  1  clears AC/L/PC/IR in the CPU
ledRun  out  1  panel RUN lamp
state  out  3  FSM state for debug: CLEARING=0, HALTED=1, RUNNING=2, HALTING=3, STEPPING=4

Behaviour:
- Every output is registered. Reset values: cpuRun=0, cpuClear=1, ledRun=0, state=CLEARING. All sync flops, debounced values and counters reset to 0.
- Synchroniser: two flops per switch.
- Debounce counter, one per switch:
  - Increments each cycle that the synchronised value differs from the debounced value.
  - Clears whenever the two match.
  - On reaching DEBOUNCE_CYCLES the debounced value flips and the counter clears.
  - Bounce shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press event: rising edge of the debounced value, exactly one cycle per press. Holding a switch never repeats the event. Release generates nothing.
- Latency: count the first edge that samples a raw level as edge 1. The FSM output change is visible after edge DEBOUNCE_CYCLES+3.
- Simultaneous press events are prioritised CLEAR > RUN > STEP > HALT. Events that are ignored in a state are dropped, not queued.
- CLEARING: cpuClear=1, cpuRun=0. The counter runs CLEAR_CYCLES cycles, then the FSM goes to HALTED with cpuClear=0.
- HALTED: cpuRun=0.
  - CLEAR press -> CLEARING, counter restarts.
  - RUN press -> RUNNING.
  - STEP press -> STEPPING.
  - HALT press is ignored.
- RUNNING: cpuRun=1.
  - instDone&instHLT -> HALTED; cpuRun=0 from that edge.
  - HALT press -> HALTING.
  - HALT press in the same cycle as instDone -> HALTED directly.
  - CLEAR, RUN and STEP are ignored.
- HALTING: cpuRun=1 until instDone, then HALTED. All presses are ignored.
- STEPPING: cpuRun=1 until the first instDone, then HALTED. Exactly one instruction completes. All presses, including HALT, are ignored.
- instDone/instHLT arriving in HALTED or CLEARING is ignored.
- ledRun=1 in RUNNING, HALTING and STEPPING; 0 otherwise.
- RESET asserted in any state, including mid-clear or mid-instruction: next edge is the reset state, cpuRun drops immediately. CLEAR_CYCLES clearing cycles follow once RESET deasserts.
- RUN held through a HLT-induced halt does not restart the CPU. A fresh press is required.

Test Plan:
Bench settings: DEBOUNCE_CYCLES=4, CLEAR_CYCLES=4.
- Reset: RESET high 2 cycles then low -> cpuClear=1 for 4 cycles after RESET falls, then 0. state goes 0->1. cpuRun=0 throughout.
- Debounced run: from HALTED, raise sw_RUN at edge 1 and hold -> cpuRun=1, ledRun=1, state=2 after edge 7 and not before. Pulse sw_RUN for 3 cycles only -> no state change.
- HLT: in RUNNING, drive instDone=instHLT=1 for one cycle -> cpuRun=0, state=1 next edge. With sw_RUN still held, 50 further cycles -> stays HALTED.
- Halt at boundary: in RUNNING, press HALT -> state=3 with cpuRun=1 held. Pulse instDone 10 cycles later -> cpuRun=0, state=1. Repeat with the HALT event coincident with instDone -> straight to state=1.
- Single step: from HALTED, press STEP -> cpuRun=1. Press HALT mid-instruction -> no effect. First instDone -> cpuRun=0, state=1. Exactly one instDone observed while cpuRun=1.
- Priority and reset: from HALTED, CLEAR and RUN debounced in the same cycle -> CLEARING, cpuClear=1 for 4 cycles, then HALTED with cpuRun=0. Assert RESET while in STEPPING -> next edge cpuRun=0, cpuClear=1, state=0.

Source files
------------

// File: rtl/panel_ctrl.sv
// Front-panel run/halt sequencer for the PDP-8 CPU: synchronises and debounces the
// panel switches and starts/stops the CPU only on instruction boundaries.
module panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CLEAR_CYCLES    = 4
) (
  input  logic       SYSCLK,
  input  logic       RESET,
  input  logic       sw_CLEAR,
  input  logic       sw_RUN,
  input  logic       sw_HALT,
  input  logic       sw_STEP,
  input  logic       instDone,
  input  logic       instHLT,
  output logic       cpuRun,
  output logic       cpuClear,
  output logic       ledRun,
  output logic [2:0] state
);

  localparam int unsigned NSW      = 4;
  localparam int unsigned DW       = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CW       = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int unsigned SW_CLEAR = 0;
  localparam int unsigned SW_RUN   = 1;
  localparam int unsigned SW_STEP  = 2;
  localparam int unsigned SW_HALT  = 3;

  typedef enum logic [2:0] {
    ST_CLEARING = 3'd0,
    ST_HALTED   = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_HALTING  = 3'd3,
    ST_STEPPING = 3'd4
  } state_t;

  logic [NSW-1:0]         raw_c;
  logic [NSW-1:0]         sync1;
  logic [NSW-1:0]         sync2;
  logic [NSW-1:0]         deb;
  logic [NSW-1:0]         deb_d;
  logic [NSW-1:0]         press_c;
  logic [NSW-1:0][DW-1:0] dcnt;

  state_t        cur;
  state_t        nxt;
  logic [CW-1:0] ccnt;
  logic [CW-1:0] ccnt_n;
  logic          run_n;
  logic          clr_n;

  assign raw_c   = {sw_HALT, sw_STEP, sw_RUN, sw_CLEAR};
  assign press_c = deb & ~deb_d;

  // Two-flop synchroniser plus per-switch debounce counter.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      dcnt  <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < NSW; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]  <= ~deb[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  // Next-state logic; presses not honoured in a state are simply dropped.
  always_comb begin
    nxt    = cur;
    ccnt_n = '0;
    case (cur)
      ST_CLEARING: begin
        if (ccnt == CW'(CLEAR_CYCLES - 1)) nxt = ST_HALTED;
        else                               ccnt_n = ccnt + CW'(1);
      end
      ST_HALTED: begin
        if      (press_c[SW_CLEAR]) nxt = ST_CLEARING;
        else if (press_c[SW_RUN])   nxt = ST_RUNNING;
        else if (press_c[SW_STEP])  nxt = ST_STEPPING;
      end
      ST_RUNNING: begin
        if (instDone && instHLT)   nxt = ST_HALTED;
        else if (press_c[SW_HALT]) nxt = instDone ? ST_HALTED : ST_HALTING;
      end
      ST_HALTING, ST_STEPPING: begin
        if (instDone) nxt = ST_HALTED;
      end
      default: nxt = ST_CLEARING;
    endcase
    run_n = (nxt == ST_RUNNING) || (nxt == ST_HALTING) || (nxt == ST_STEPPING);
    clr_n = (nxt == ST_CLEARING);
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      cur      <= ST_CLEARING;
      ccnt     <= '0;
      cpuRun   <= 1'b0;
      cpuClear <= 1'b1;
      ledRun   <= 1'b0;
    end else begin
      cur      <= nxt;
      ccnt     <= ccnt_n;
      cpuRun   <= run_n;
      cpuClear <= clr_n;
      ledRun   <= run_n;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_panel_ctrl.sv
// Bench for panel_ctrl: directed scenarios plus random switch/instruction traffic,
// compared every cycle against a window-based debounce and state-rule model.
module tb_panel_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned CC = 4;
  localparam int CLR = 0;
  localparam int RUN = 1;
  localparam int STP = 2;
  localparam int HLT = 3;

  logic       SYSCLK = 1'b0;
  logic       RESET;
  logic [3:0] sw;
  logic       instDone;
  logic       instHLT;
  logic       cpuRun;
  logic       cpuClear;
  logic       ledRun;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 SYSCLK = ~SYSCLK;

  panel_ctrl #(.DEBOUNCE_CYCLES(DB), .CLEAR_CYCLES(CC)) dut (
    .SYSCLK  (SYSCLK),
    .RESET   (RESET),
    .sw_CLEAR(sw[CLR]),
    .sw_RUN  (sw[RUN]),
    .sw_HALT (sw[HLT]),
    .sw_STEP (sw[STP]),
    .instDone(instDone),
    .instHLT (instHLT),
    .cpuRun  (cpuRun),
    .cpuClear(cpuClear),
    .ledRun  (ledRun),
    .state   (state)
  );

  // Reference model: a level flips once the last DB synchronised samples all disagree.
  int m_state = 0;
  int m_ccnt  = 0;
  bit hist [4][DB+1];
  bit m_deb [4];
  bit m_debp [4];
  bit last_run = 1'b0;
  int done_while_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit press [4];
    bit all_diff;
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        m_deb[i]  = 1'b0;
        m_debp[i] = 1'b0;
        for (int k = 0; k <= DB; k++) hist[i][k] = 1'b0;
      end
      m_state = 0;
      m_ccnt  = 0;
      return;
    end
    for (int i = 0; i < 4; i++) press[i] = m_deb[i] && !m_debp[i];
    case (m_state)
      0: begin
        if (m_ccnt == CC - 1) begin m_state = 1; m_ccnt = 0; end
        else m_ccnt++;
      end
      1: begin
        if (press[CLR])      begin m_state = 0; m_ccnt = 0; end
        else if (press[RUN]) m_state = 2;
        else if (press[STP]) m_state = 4;
      end
      2: begin
        if (instDone && instHLT) m_state = 1;
        else if (press[HLT])     m_state = instDone ? 1 : 3;
      end
      default: if (instDone) m_state = 1;
    endcase
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= DB; k++) if (hist[i][k] == m_deb[i]) all_diff = 1'b0;
      m_debp[i] = m_deb[i];
      if (all_diff) m_deb[i] = !m_deb[i];
      for (int k = DB; k >= 1; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = sw[i];
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    if (instDone && last_run) done_while_run++;
    model_step();
    @(negedge SYSCLK);
    chk("state",    32'(state),    32'(m_state));
    chk("cpuRun",   32'(cpuRun),   32'(m_state >= 2));
    chk("cpuClear", 32'(cpuClear), 32'(m_state == 0));
    chk("ledRun",   32'(ledRun),   32'(m_state >= 2));
    last_run = cpuRun;
  endtask

  task automatic press_sw(input int i);
    sw[i] = 1'b1;
    repeat (DB + 3) tick();
    sw[i] = 1'b0;
    repeat (DB + 3) tick();
  endtask

  initial begin
    RESET    = 1'b1;
    sw       = '0;
    instDone = 1'b0;
    instHLT  = 1'b0;

    // Reset and power-up clearing
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_clear", 32'(cpuClear), 1);
    chk("rst_run",   32'(cpuRun), 0);
    chk("rst_led",   32'(ledRun), 0);
    RESET = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("clr_len",   32'(cpuClear), (k < 4) ? 1 : 0);
      chk("clr_state", 32'(state),    (k < 4) ? 0 : 1);
      chk("clr_run",   32'(cpuRun), 0);
    end

    // Short bounce is filtered
    sw[RUN] = 1'b1;
    repeat (3) tick();
    sw[RUN] = 1'b0;
    repeat (10) tick();
    chk("bounce_state", 32'(state), 1);

    // Held RUN takes effect exactly after edge 7
    sw[RUN] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) chk("run_early", 32'(state), 1);
    end
    chk("run_state", 32'(state), 2);
    chk("run_cpu",   32'(cpuRun), 1);
    chk("run_led",   32'(ledRun), 1);

    // OPR HLT halts, held RUN does not restart
    instDone = 1'b1; instHLT = 1'b1;
    tick();
    instDone = 1'b0; instHLT = 1'b0;
    chk("hlt_state", 32'(state), 1);
    chk("hlt_run",   32'(cpuRun), 0);
    repeat (50) tick();
    chk("hlt_hold", 32'(state), 1);
    sw[RUN] = 1'b0;
    repeat (DB + 3) tick();

    // HALT waits for the instruction boundary
    press_sw(RUN);
    chk("run2_state", 32'(state), 2);
    sw[HLT] = 1'b1;
    repeat (DB + 3) tick();
    chk("halting_state", 32'(state), 3);
    chk("halting_run",   32'(cpuRun), 1);
    sw[HLT] = 1'b0;
    repeat (10) tick();
    chk("halting_hold", 32'(state), 3);
    instDone = 1'b1;
    tick();
    instDone = 1'b0;
    chk("halted_state", 32'(state), 1);
    chk("halted_run",   32'(cpuRun), 0);

    // HALT press coincident with instDone goes straight to HALTED
    press_sw(RUN);
    sw[HLT] = 1'b1;
    repeat (DB + 2) tick();
    chk("coin_pre", 32'(state), 2);
    instDone = 1'b1;
    tick();
    instDone = 1'b0;
    chk("coin_state", 32'(state), 1);
    sw[HLT] = 1'b0;
    repeat (DB + 3) tick();

    // Single step: HALT ignored, one instruction
    done_while_run = 0;
    sw[STP] = 1'b1;
    repeat (DB + 3) tick();
    sw[STP] = 1'b0;
    chk("step_state", 32'(state), 4);
    chk("step_run",   32'(cpuRun), 1);
    repeat (3) tick();
    sw[HLT] = 1'b1;
    repeat (DB + 3) tick();
    sw[HLT] = 1'b0;
    chk("step_halt_ignored", 32'(state), 4);
    repeat (DB + 3) tick();
    instDone = 1'b1;
    tick();
    instDone = 1'b0;
    chk("step_done_state", 32'(state), 1);
    chk("step_done_run",   32'(cpuRun), 0);
    repeat (3) tick();
    instDone = 1'b1;
    tick();
    instDone = 1'b0;
    repeat (2) tick();
    chk("step_one_inst", 32'(done_while_run), 1);

    // CLEAR beats RUN
    sw[CLR] = 1'b1; sw[RUN] = 1'b1;
    repeat (DB + 3) tick();
    chk("prio_state", 32'(state), 0);
    chk("prio_clear", 32'(cpuClear), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("prio_len",   32'(cpuClear), (k < 4) ? 1 : 0);
      chk("prio_st",    32'(state),    (k < 4) ? 0 : 1);
      chk("prio_run",   32'(cpuRun), 0);
    end
    sw = '0;
    repeat (DB + 3) tick();

    // RESET while stepping
    sw[STP] = 1'b1;
    repeat (DB + 3) tick();
    sw[STP] = 1'b0;
    chk("rst_step_pre", 32'(state), 4);
    RESET = 1'b1;
    tick();
    chk("rst_step_run",   32'(cpuRun), 0);
    chk("rst_step_clear", 32'(cpuClear), 1);
    chk("rst_step_state", 32'(state), 0);
    RESET = 1'b0;
    repeat (CC + DB + 3) tick();
    chk("rst_step_after", 32'(state), 1);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 9) == 0) sw[i] = ~sw[i];
      instDone = ($urandom_range(0, 5) == 0);
      instHLT  = instDone && ($urandom_range(0, 3) == 0);
      RESET    = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
